// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// ALU-control decode, ALU, branch-target adder and destination-register mux,
// all registered into the EX/MEM pipeline register.
// Optional feature: define MULT_EN to add an iterative shift-add multiplier
// (funct 011000) that stalls the upstream pipeline while it runs.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout,
  output logic        stall_out
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NONE
  } alu_sel_e;

  logic [5:0]  funct;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic [31:0] br_target;
  logic [4:0]  dst;
  logic [31:0] res_alu;
  logic        res_zero;
  alu_sel_e    alu_sel;

  assign funct     = s_extend[5:0];
  assign op_b      = alusrc ? s_extend : rdata2;
  assign br_target = npc + {s_extend[29:0], 2'b00};
  assign dst       = regdst ? instr_1511 : instr_2016;

  // ALU control: map aluop (and funct for R-type) onto an ALU operation
  always_comb begin
    alu_sel = ALU_NONE;
    case (aluop)
      2'b00: alu_sel = ALU_ADD;
      2'b01: alu_sel = ALU_SUB;
      2'b11: alu_sel = ALU_ADD;
      default: begin
        case (funct)
          6'b100000: alu_sel = ALU_ADD;
          6'b100010: alu_sel = ALU_SUB;
          6'b100100: alu_sel = ALU_AND;
          6'b100101: alu_sel = ALU_OR;
          6'b101010: alu_sel = ALU_SLT;
          default:   alu_sel = ALU_NONE;
        endcase
      end
    endcase
  end

  // ALU datapath; unknown functs produce 0
  always_comb begin
    alu_y = '0;
    case (alu_sel)
      ALU_ADD: alu_y = rdata1 + op_b;
      ALU_SUB: alu_y = rdata1 - op_b;
      ALU_AND: alu_y = rdata1 & op_b;
      ALU_OR:  alu_y = rdata1 | op_b;
      ALU_SLT: alu_y = ($signed(rdata1) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_y = '0;
    endcase
  end

`ifdef MULT_EN
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } mult_state_e;

  mult_state_e state;
  mult_state_e state_nxt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        is_mult;

  assign is_mult = (aluop == 2'b10) && (funct == 6'b011000);

  // Multiplier state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and stall; DONE always returns to IDLE so a held multiply
  // does not immediately restart in the same cycle its result is captured
  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        stall_out = is_mult;
        if (is_mult && !flush) state_nxt = MUL;
      end
      MUL: begin
        stall_out = 1'b1;
        if (cnt == 5'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Shift-add datapath: one partial product per cycle, low 32 bits kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (!flush) begin
      if (state == IDLE && is_mult) begin
        mul_a <= rdata1;
        mul_b <= op_b;
        acc   <= '0;
        cnt   <= 5'd31;
      end else if (state == MUL) begin
        acc   <= acc + (mul_b[0] ? mul_a : 32'd0);
        mul_a <= {mul_a[30:0], 1'b0};
        mul_b <= {1'b0, mul_b[31:1]};
        if (cnt != 5'd0) cnt <= cnt - 5'd1;
      end
    end
  end

  // Result selection: the product replaces the ALU result in DONE
  always_comb begin
    res_alu  = alu_y;
    res_zero = (alu_y == 32'd0);
    if (state == DONE) begin
      res_alu  = acc;
      res_zero = (acc == 32'd0);
    end
  end
`else
  assign stall_out = 1'b0;

  // Result selection: ALU result only
  always_comb begin
    res_alu  = alu_y;
    res_zero = (alu_y == 32'd0);
  end
`endif

  // EX/MEM pipeline register: flush loads a bubble, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
    end else if (flush) begin
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
    end else if (!stall_out) begin
      wb_ctlout  <= wb_ctl;
      m_ctlout   <= m_ctl;
      add_result <= br_target;
      zero       <= res_zero;
      alu_result <= res_alu;
      rdata2out  <= rdata2;
      muxout     <= dst;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage. Stimulus pushes hand-computed expectations;
// a monitor pops and compares whenever the DUT captures into EX/MEM.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  muxout;
  logic        stall_out;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .muxout(muxout), .stall_out(stall_out)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        z;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  mux;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic pending    = 1'b0;

`ifdef MULT_EN
  localparam int MSTALL = 33;
`else
  localparam int MSTALL = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] w, input logic [2:0] m,
                              input logic [31:0] ad, input logic z,
                              input logic [31:0] al, input logic [31:0] r2,
                              input logic [4:0] mx, input int st);
    exp_t e;
    e.wb = w; e.m = m; e.add = ad; e.z = z; e.alu = al; e.rd2 = r2; e.mux = mx; e.stalls = st;
    return e;
  endfunction

  task automatic drive(input logic fl, input logic [1:0] w, input logic [2:0] m,
                       input logic rd, input logic as, input logic [1:0] op,
                       input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [4:0] i20, input logic [4:0] i15);
    flush = fl; wb_ctl = w; m_ctl = m; regdst = rd; alusrc = as; aluop = op;
    npc = n; rdata1 = a; rdata2 = b; s_extend = s; instr_2016 = i20; instr_1511 = i15;
  endtask

  // Called at posedge+2; returns at posedge+2 after the monitor has consumed the result
  task automatic send(input logic fl, input logic [1:0] w, input logic [2:0] m,
                      input logic rd, input logic as, input logic [1:0] op,
                      input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] s, input logic [4:0] i20, input logic [4:0] i15,
                      input exp_t e);
    drive(fl, w, m, rd, as, op, n, a, b, s, i20, i15);
    sb.push_back(e);
    pending = 1'b1;
    for (int g = 0; g < 300 && pending; g++) begin
      @(posedge clk);
      #2;
    end
    if (pending) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got pending=1, expected result within 300 cycles");
      pending = 1'b0;
      sb.delete();
    end
  endtask

  // Monitor: counts stall cycles, then compares the EX/MEM capture
  initial begin : monitor
    exp_t e;
    int   nst;
    nst = 0;
    forever begin
      @(negedge clk);
      if (pending && rst_n) begin
        if (stall_out) begin
          nst++;
          if (nst > 100) begin
            compared++;
            mismatched++;
            $display("FAIL stall_timeout: got %0d stall cycles, expected %0d", nst, MSTALL);
            if (sb.size() > 0) void'(sb.pop_front());
            nst = 0;
            pending = 1'b0;
          end
        end else begin
          @(posedge clk);
          #1;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_ctlout",  {30'd0, wb_ctlout}, {30'd0, e.wb});
            chk("m_ctlout",   {29'd0, m_ctlout},  {29'd0, e.m});
            chk("add_result", add_result,         e.add);
            chk("zero",       {31'd0, zero},      {31'd0, e.z});
            chk("alu_result", alu_result,         e.alu);
            chk("rdata2out",  rdata2out,          e.rd2);
            chk("muxout",     {27'd0, muxout},    {27'd0, e.mux});
            chk("stall_cycles", nst,              e.stalls);
          end
          nst = 0;
          pending = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0);
    #1;
    chk("reset_wb",    {30'd0, wb_ctlout}, 32'd0);
    chk("reset_alu",   alu_result,         32'd0);
    chk("reset_zero",  {31'd0, zero},      32'd0);
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // sub R-type, regdst=1
    send(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h40, 32'd5, 32'd7, 32'h22, 5'd3, 5'd9,
         mk(2'b10, 3'b000, 32'hC8, 1'b0, 32'hFFFFFFFE, 32'd7, 5'd9, 0));
    // beq compare, negative offset
    send(1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFF, 5'd4, 5'd5,
         mk(2'b00, 3'b100, 32'hFC, 1'b1, 32'h0, 32'h1234, 5'd4, 0));
    // slt signed: -1 < 1
    send(1'b0, 2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd2, 5'd7,
         mk(2'b01, 3'b000, 32'hA8, 1'b0, 32'd1, 32'd1, 5'd7, 0));
    // slt swapped: 1 < -1 false
    send(1'b0, 2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd2, 5'd7,
         mk(2'b01, 3'b000, 32'hA8, 1'b1, 32'd0, 32'hFFFFFFFF, 5'd7, 0));
    // load address: immediate operand, regdst=0
    send(1'b0, 2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h20, 32'h1000, 32'hAA, 32'hFFFFFFF0, 5'd8, 5'd1,
         mk(2'b11, 3'b010, 32'hFFFFFFE0, 1'b0, 32'h00000FF0, 32'hAA, 5'd8, 0));
    // and
    send(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h24, 5'd0, 5'd11,
         mk(2'b10, 3'b000, 32'h90, 1'b0, 32'hF000F000, 32'hFF00FF00, 5'd11, 0));
    // or
    send(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h25, 5'd0, 5'd12,
         mk(2'b10, 3'b000, 32'h94, 1'b0, 32'hFFF0FFF0, 32'hFF00FF00, 5'd12, 0));
    // aluop=11 add wraps to zero
    send(1'b0, 2'b01, 3'b001, 1'b0, 1'b0, 2'b11, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd13, 5'd14,
         mk(2'b01, 3'b001, 32'h8, 1'b1, 32'h0, 32'd1, 5'd13, 0));
    // unknown funct -> 0
    send(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd3, 32'd4, 32'h3F, 5'd0, 5'd15,
         mk(2'b10, 3'b000, 32'hFC, 1'b1, 32'h0, 32'd4, 5'd15, 0));
    // flush over a valid op -> bubble
    send(1'b1, 2'b10, 3'b111, 1'b1, 1'b0, 2'b10, 32'h40, 32'd5, 32'd7, 32'h22, 5'd3, 5'd9,
         mk(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 0));

    // flush mid-multiply: upstream replaces the multiply while flushing
    drive(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h200, 32'hFFFFFFFD, 32'd7, 32'h18, 5'd0, 5'd10);
    repeat (10) @(posedge clk);
    #2;
    chk("stall_mid_mult", {31'd0, stall_out}, (MSTALL != 0) ? 32'd1 : 32'd0);
    drive(1'b1, 2'b11, 3'b111, 1'b1, 1'b0, 2'b00, 32'h4, 32'd1, 32'd2, 32'h0, 5'd1, 5'd2);
    @(posedge clk);
    #1;
    chk("flush_wb",    {30'd0, wb_ctlout}, 32'd0);
    chk("flush_m",     {29'd0, m_ctlout},  32'd0);
    chk("flush_alu",   alu_result,         32'd0);
    chk("flush_stall", {31'd0, stall_out}, 32'd0);
    #1;

    // multiply -3 * 7 (also shows the FSM restarted from IDLE)
    send(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h200, 32'hFFFFFFFD, 32'd7, 32'h18, 5'd0, 5'd10,
         mk(2'b10, 3'b000, 32'h260, (MSTALL == 0), (MSTALL != 0) ? 32'hFFFFFFEB : 32'h0, 32'd7, 5'd10, MSTALL));
    // back-to-back multiply, product low word wraps to zero
    send(1'b0, 2'b11, 3'b011, 1'b1, 1'b0, 2'b10, 32'h300, 32'h00010000, 32'h00010000, 32'h18, 5'd0, 5'd20,
         mk(2'b11, 3'b011, 32'h360, 1'b1, 32'h0, 32'h00010000, 5'd20, MSTALL));

    // asynchronous reset in the middle of a multiply
    drive(1'b0, 2'b01, 3'b001, 1'b1, 1'b0, 2'b10, 32'h200, 32'd6, 32'd7, 32'h18, 5'd0, 5'd10);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    aluop = 2'b00;
    #1;
    chk("rst_wb",    {30'd0, wb_ctlout}, 32'd0);
    chk("rst_m",     {29'd0, m_ctlout},  32'd0);
    chk("rst_add",   add_result,         32'd0);
    chk("rst_alu",   alu_result,         32'd0);
    chk("rst_rd2",   rdata2out,          32'd0);
    chk("rst_mux",   {27'd0, muxout},    32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline: consumes the decoded control and operand fields delivered by the ID/EX latch, performs ALU-control decode, the ALU operation, branch-target addition and destination-register selection, and registers the results into the EX/MEM pipeline register. An optional iterative multiplier extends the stage to a multi-cycle operation and stalls the upstream pipeline while it runs.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; load a bubble into EX/MEM
- wb_ctl  in  2  WB control from ID/EX, passed through
- m_ctl  in  3  MEM control {branch, memread, memwrite}, passed through
- regdst  in  1  1 selects instr_1511, 0 selects instr_2016
- alusrc  in  1  1 selects s_extend as ALU operand B, 0 selects rdata2
- aluop  in  2  ALU operation class
- npc, rdata1, rdata2, s_extend  in  32 each  next PC, register operands, sign-extended immediate
- instr_2016, instr_1511  in  5 each  candidate destination registers
- wb_ctlout  out  2 / m_ctlout  out  3  registered control
- add_result  out  32  registered branch target
- zero  out  1  registered (ALU result == 0)
- alu_result  out  32  registered ALU result
- rdata2out  out  32  registered rdata2 (store data)
- muxout  out  5  registered destination register
- stall_out  out  1  combinational; 1 = upstream must hold

## Operation
- ALU control from aluop: 00 add; 01 sub; 11 add; 10 decode funct = s_extend[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0); any other funct -> result 0.
- Operand A = rdata1; B = alusrc ? s_extend : rdata2. Add/sub 32-bit, wrap, no overflow flag.
- add_result = npc + (s_extend << 2), truncated to 32 bits.
- muxout = regdst ? instr_1511 : instr_2016.
- EX/MEM register: on each edge with stall_out=0 and flush=0 captures all outputs above; stall_out=1 holds all outputs.
- Multiplier FSM (MULT_EN only), states IDLE, MUL, DONE; is_mult = aluop==10 && funct==011000.
  - IDLE & is_mult & !flush: latch A and B, acc=0, cnt=31, -> MUL.
  - MUL: one shift-add step per cycle (acc += B[0] ? A : 0; A<<=1; B>>=1); cnt==0 at step -> DONE, else cnt-1.
  - DONE: EX/MEM captures alu_result = acc (low 32 bits of product, identical for signed/unsigned), zero from acc; -> IDLE.
- stall_out = (IDLE & is_mult) | MUL.
- flush has priority: EX/MEM loads wb_ctlout=0, m_ctlout=0, other fields 0; FSM aborts to IDLE from any state.

## Timing
- Reset: all outputs 0, FSM IDLE, acc and cnt 0; takes effect immediately, including mid-multiply.
- Non-multiply ops: 1-cycle latency, inputs at edge N appear on outputs after edge N.
- Multiply: stall_out high for exactly 33 cycles (1 in IDLE, 32 in MUL); result visible after the 34th edge (the DONE edge). Upstream holds inputs stable throughout; in DONE is_mult is still true but must not restart.
- Back-to-back multiplies: second one enters IDLE after DONE and stalls another 33 cycles.
- flush and stall same cycle: flush wins; stall_out drops next cycle.

## Configuration
- MULT_EN defined: FSM and funct 011000 multiply implemented as above.
- MULT_EN undefined: no FSM; funct 011000 is an unknown funct (result 0, single cycle); stall_out tied to 0.

## Test plan
- Reset: rst_n=0 mid-run -> all outputs 0 immediately; stall_out=0.
- R-type: aluop=10, funct=100010, rdata1=5, rdata2=7, regdst=1, instr_1511=9 -> after one edge alu_result=0xFFFFFFFE, zero=0, muxout=9.
- Branch: aluop=01, rdata1=rdata2=0x1234, npc=0x100, s_extend=0xFFFFFFFF -> zero=1, add_result=0xFC.
- slt signed: rdata1=0xFFFFFFFF, rdata2=1, funct=101010 -> alu_result=1; swapped -> 0.
- Multiply (MULT_EN): rdata1=0xFFFFFFFD, rdata2=7 -> stall_out high 33 cycles, then alu_result=0xFFFFFFEB; without MULT_EN -> alu_result=0, no stall.
- Flush mid-multiply at cycle 10 -> wb_ctlout=0, m_ctlout=0, stall_out=0 next cycle, FSM IDLE.
